// File: rtl/countdown_timer.sv
// Memory-mapped programmable down-counter with prescaler, sticky expiry flag,
// level interrupt, and one-shot or auto-reload operation.
module countdown_timer #(
    parameter int WIDTH   = 32,
    parameter int PRESC_W = 8
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_wr_en,
    input  logic [3:0]  i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_irq
);

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_LOAD   = 2'd1;
    localparam logic [1:0] REG_VALUE  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    logic               en;
    logic               ar;
    logic               ie;
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] pcnt;
    logic [WIDTH-1:0]   load;
    logic [WIDTH-1:0]   value;
    logic               exp_flag;

    logic wr_ctrl;
    logic wr_load;
    logic wr_status;
    logic tick;
    logic expire;
    logic unused_addr;

    assign wr_ctrl     = i_wr_en && (i_addr[3:2] == REG_CTRL);
    assign wr_load     = i_wr_en && (i_addr[3:2] == REG_LOAD);
    assign wr_status   = i_wr_en && (i_addr[3:2] == REG_STATUS);
    assign tick        = en && (pcnt == presc);
    assign expire      = tick && (value == '0);
    assign unused_addr = ^i_addr[1:0];

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            en       <= 1'b0;
            ar       <= 1'b0;
            ie       <= 1'b0;
            presc    <= '0;
            pcnt     <= '0;
            load     <= '0;
            value    <= '0;
            exp_flag <= 1'b0;
        end else begin
            // A CTRL write overrides the one-shot self-disable on expiry
            if (wr_ctrl) begin
                en    <= i_wdata[0];
                ar    <= i_wdata[1];
                ie    <= i_wdata[2];
                presc <= i_wdata[8 +: PRESC_W];
            end else if (expire && !ar) begin
                en <= 1'b0;
            end

            if (wr_load) begin
                load  <= i_wdata[WIDTH-1:0];
                value <= i_wdata[WIDTH-1:0];
            end else if (tick) begin
                if (value != '0)
                    value <= value - WIDTH'(1);
                else if (ar)
                    value <= load;
            end

            // Prescaler restarts on LOAD writes, on enable, and while idle
            if (wr_load)
                pcnt <= '0;
            else if (wr_ctrl && (!i_wdata[0] || !en))
                pcnt <= '0;
            else if (!en || tick)
                pcnt <= '0;
            else
                pcnt <= pcnt + PRESC_W'(1);

            // Expiry beats a simultaneous write-one-to-clear
            if (expire)
                exp_flag <= 1'b1;
            else if (wr_status && i_wdata[0])
                exp_flag <= 1'b0;
        end
    end

    always_comb begin
        o_rdata = '0;
        case (i_addr[3:2])
            REG_CTRL: begin
                o_rdata[0]              = en;
                o_rdata[1]              = ar;
                o_rdata[2]              = ie;
                o_rdata[8 +: PRESC_W]   = presc;
            end
            REG_LOAD:   o_rdata[WIDTH-1:0] = load;
            REG_VALUE:  o_rdata[WIDTH-1:0] = value;
            REG_STATUS: o_rdata[0]         = exp_flag;
            default:    o_rdata            = '0;
        endcase
    end

    assign o_irq = exp_flag & ie;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: per-cycle bus actions and expected
// read/irq values are queued, then replayed and compared cycle by cycle.
module tb_countdown_timer;

    localparam logic [3:0] A_CTRL   = 4'h0;
    localparam logic [3:0] A_LOAD   = 4'h4;
    localparam logic [3:0] A_VALUE  = 4'h8;
    localparam logic [3:0] A_STATUS = 4'hC;

    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic        i_wr_en;
    logic [3:0]  i_addr;
    logic [31:0] i_wdata;
    logic [31:0] o_rdata;
    logic        o_irq;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        string       tag;
        bit          wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
        bit          chk;
        logic [31:0] exp_rd;
        bit          exp_irq;
    } sb_t;

    sb_t sb_q[$];

    countdown_timer #(.WIDTH(32), .PRESC_W(8)) dut (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_wr_en (i_wr_en),
        .i_addr  (i_addr),
        .i_wdata (i_wdata),
        .o_rdata (o_rdata),
        .o_irq   (o_irq)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input bit wr, input logic [3:0] addr,
                           input logic [31:0] wdata, input bit chk,
                           input logic [31:0] exp_rd, input bit exp_irq);
        sb_t e;
        e.tag = tag; e.wr = wr; e.addr = addr; e.wdata = wdata;
        e.chk = chk; e.exp_rd = exp_rd; e.exp_irq = exp_irq;
        sb_q.push_back(e);
    endtask

    task automatic sb_wr(input logic [3:0] addr, input logic [31:0] wdata);
        sb_push("wr", 1'b1, addr, wdata, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic sb_rd(input string tag, input logic [3:0] addr,
                         input logic [31:0] exp_rd, input bit exp_irq);
        sb_push(tag, 1'b0, addr, 32'h0, 1'b1, exp_rd, exp_irq);
    endtask

    // Each entry occupies one clock cycle; reads are sampled before the edge
    task automatic drain();
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            i_wr_en = e.wr;
            i_addr  = e.addr;
            i_wdata = e.wdata;
            #1;
            if (e.chk) begin
                check_eq({e.tag, ".rd"}, o_rdata, e.exp_rd);
                check_eq({e.tag, ".irq"}, {31'b0, o_irq}, {31'b0, e.exp_irq});
            end
            @(posedge i_clk);
            #1;
            i_wr_en = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] addr8;
        i_rstn  = 1'b1;
        i_wr_en = 1'b0;
        i_addr  = 4'h0;
        i_wdata = 32'h0;
        #2 i_rstn = 1'b0;
        #1;
        for (int a = 0; a < 4; a++) begin
            i_addr = 4'(a * 4);
            #1;
            check_eq($sformatf("rst_init_a%0d", a * 4), o_rdata, 32'h0);
        end
        check_eq("rst_init_irq", {31'b0, o_irq}, 32'h0);
        @(negedge i_clk) i_rstn = 1'b1;
        @(posedge i_clk);
        #1;

        // Reset in the middle of a run
        sb_wr(A_LOAD, 32'd10);
        sb_wr(A_CTRL, 32'h1);
        for (int c = 1; c <= 5; c++)
            sb_rd($sformatf("prerst_c%0d", c), A_VALUE, 32'(11 - c), 1'b0);
        drain();
        i_addr = A_VALUE;
        #1;
        check_eq("prerst_value5", o_rdata, 32'd5);
        #1 i_rstn = 1'b0;
        #1;
        for (int a = 0; a < 4; a++) begin
            i_addr = 4'(a * 4);
            #1;
            check_eq($sformatf("rst_mid_a%0d", a * 4), o_rdata, 32'h0);
        end
        check_eq("rst_mid_irq", {31'b0, o_irq}, 32'h0);
        @(negedge i_clk) i_rstn = 1'b1;
        @(posedge i_clk);
        #1;
        for (int c = 1; c <= 3; c++)
            sb_rd($sformatf("postrst_val_c%0d", c), A_VALUE, 32'h0, 1'b0);
        sb_rd("postrst_ctrl", A_CTRL, 32'h0, 1'b0);
        drain();

        // One-shot
        sb_wr(A_LOAD, 32'd3);
        sb_wr(A_CTRL, 32'h5);
        for (int c = 1; c <= 4; c++)
            sb_rd($sformatf("oneshot_c%0d", c), A_VALUE, 32'(4 - c), 1'b0);
        sb_rd("oneshot_ctrl_en0", A_CTRL, 32'h4, 1'b1);
        sb_rd("oneshot_hold0", A_VALUE, 32'h0, 1'b1);
        sb_push("oneshot_w1c", 1'b1, A_STATUS, 32'h1, 1'b1, 32'h1, 1'b1);
        sb_rd("oneshot_cleared", A_STATUS, 32'h0, 1'b0);
        drain();

        // Periodic with prescaler 3, including a clear/expire collision at c24
        sb_wr(A_LOAD, 32'd2);
        sb_wr(A_CTRL, 32'h0000_0307);
        for (int c = 1; c <= 37; c++) begin
            if (c == 13 || c == 25)
                sb_push($sformatf("per_w1c_c%0d", c), 1'b1, A_STATUS, 32'h1, 1'b1, 32'h1, 1'b1);
            else if (c == 24)
                sb_push("per_collide_c24", 1'b1, A_STATUS, 32'h1, 1'b1, 32'h0, 1'b0);
            else if (c == 26)
                sb_rd("per_cleared_c26", A_STATUS, 32'h0, 1'b0);
            else if (c == 37)
                sb_rd("per_exp3_c37", A_STATUS, 32'h1, 1'b1);
            else
                sb_rd($sformatf("per_val_c%0d", c), A_VALUE, 32'(2 - ((c - 1) % 12) / 4), 1'b0);
        end
        drain();

        // Reload mid-run, pause, ignored VALUE write, resume
        sb_wr(A_CTRL, 32'h0);
        sb_wr(A_STATUS, 32'h1);
        sb_wr(A_LOAD, 32'd9);
        sb_wr(A_CTRL, 32'h0000_0301);
        for (int c = 1; c <= 48; c++) begin
            if (c <= 9)
                sb_rd($sformatf("rl_val_c%0d", c), A_VALUE, 32'(9 - (c - 1) / 4), 1'b0);
            else if (c == 10)
                sb_push("rl_load20", 1'b1, A_LOAD, 32'd20, 1'b1, 32'd9, 1'b0);
            else if (c <= 30)
                sb_rd($sformatf("rl_val_c%0d", c), A_VALUE, 32'(20 - (c - 11) / 4), 1'b0);
            else if (c == 31)
                sb_push("rl_pause", 1'b1, A_CTRL, 32'h0000_0300, 1'b1, 32'h0000_0301, 1'b0);
            else if (c == 36)
                sb_push("rl_wr_value", 1'b1, A_VALUE, 32'h55, 1'b1, 32'd15, 1'b0);
            else if (c <= 41)
                sb_rd($sformatf("rl_hold_c%0d", c), A_VALUE, 32'd15, 1'b0);
            else if (c == 42)
                sb_push("rl_resume", 1'b1, A_CTRL, 32'h0000_0301, 1'b1, 32'h0000_0300, 1'b0);
            else
                sb_rd($sformatf("rl_val_c%0d", c), A_VALUE, (c <= 46) ? 32'd15 : 32'd14, 1'b0);
        end
        drain();

        // LOAD=0 with auto-reload: expiry every tick, clears always lose
        sb_wr(A_CTRL, 32'h0);
        sb_wr(A_LOAD, 32'h0);
        sb_wr(A_CTRL, 32'h7);
        sb_rd("zero_c1", A_VALUE, 32'h0, 1'b0);
        for (int c = 2; c <= 5; c++)
            sb_push($sformatf("zero_w1c_c%0d", c), 1'b1, A_STATUS, 32'h1, 1'b1, 32'h1, 1'b1);
        sb_rd("zero_val", A_VALUE, 32'h0, 1'b1);
        addr8 = 8'h10;
        sb_rd("alias_0x10", addr8[3:0], 32'h7, 1'b1);
        drain();

        // Full-width start value
        sb_wr(A_CTRL, 32'h0);
        sb_wr(A_STATUS, 32'h1);
        sb_wr(A_LOAD, 32'hFFFF_FFFF);
        sb_wr(A_CTRL, 32'h1);
        for (int c = 1; c <= 3; c++)
            sb_rd($sformatf("max_c%0d", c), A_VALUE, 32'hFFFF_FFFF - 32'(c - 1), 1'b0);
        sb_rd("max_status", A_STATUS, 32'h0, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Memory-mapped programmable down-counter on the processor's peripheral bus; it is the event-generating counterpart to the free-running up-counting `timer`. Software loads a start value, and the block counts down in prescaled ticks to zero. On reaching zero it raises a sticky expiry flag and an optional level interrupt, then either reloads (periodic mode) or stops (one-shot mode). All counter arithmetic is WIDTH bits wide and wraps modulo 2^WIDTH.

## Interface
- WIDTH, 32: counter and LOAD register width (≤32); narrower values zero-extend on read.
- PRESC_W, 8: prescaler field width; tick period is PRESC+1 clock cycles.
- i_clk  in  1  clock.
- i_rstn  in  1  reset, asynchronous, active-low.
- i_wr_en  in  1  write strobe, one register write per asserted cycle.
- i_addr  in  4  byte address; only word offsets 0x0/0x4/0x8/0xC are decoded; bits[1:0] ignored.
- i_wdata  in  32  write data.
- o_rdata  out  32  combinational read data for i_addr.
- o_irq  out  1  interrupt, level, = STATUS.EXP & CTRL.IE.

## Operation
- Register map:
  - 0x0 CTRL (R/W): bit0 EN, bit1 AR (auto-reload), bit2 IE (irq enable), bits[8+PRESC_W-1:8] PRESC, other bits read 0.
  - 0x4 LOAD (R/W).
  - 0x8 VALUE (RO; writes ignored).
  - 0xC STATUS: bit0 EXP; a write of 1 to bit0 clears it, a write of 0 has no effect.
  - Unmapped bits and addresses read 0.
- States: IDLE (EN=0), RUN (EN=1). EN is the state bit; no other state exists.
- Prescaler: PRESC_W-bit counter `pcnt`.
  - In RUN, `pcnt` increments each cycle.
  - When `pcnt==PRESC`, a tick is issued and `pcnt`←0.
  - In IDLE, `pcnt` holds 0.
- On a tick:
  - If VALUE≠0: VALUE←VALUE−1.
  - If VALUE==0: expire. EXP←1.
    - If AR=1: VALUE←LOAD and stay in RUN.
    - If AR=0: EN←0 (→IDLE) and VALUE stays 0.
- Expiry period: (LOAD+1)·(PRESC+1) cycles from start.
- LOAD write: LOAD←wdata and VALUE←wdata (truncated to WIDTH), in any state. `pcnt`←0.
- CTRL write: fields are updated.
  - EN 0→1 clears `pcnt`.
  - EN 1→0 freezes VALUE.
  - Re-enabling resumes from the frozen VALUE.
- LOAD=0 with AR=1: expiry on every tick.

## Timing
- Reset values: CTRL=0, LOAD=0, VALUE=0, STATUS=0, `pcnt`=0, o_irq=0, o_rdata = f(i_addr) with all registers 0.
- Writes take effect at the next rising edge. Reads are same-cycle combinational and show pre-edge values, including a register written in the same cycle.
- VALUE update latency: a tick at edge N is visible on a read in cycle N+1.
- EXP and o_irq assert in the cycle after the expiring edge. o_irq follows IE combinationally from the registered EXP.
- Simultaneous events:
  - Expiry in the same cycle as a STATUS W1C write: set wins, EXP=1.
  - Expiry in the same cycle as a LOAD write: the LOAD write wins for VALUE and `pcnt`, but EXP is still set.
  - Expiry in the same cycle as a CTRL write: the CTRL write wins for EN, AR, IE and PRESC; EXP is still set.
  - Tick in the same cycle as a LOAD write: the LOAD write wins.
- Async reset mid-count returns all state to reset values immediately. The first count after reset requires a LOAD write and EN=1.

## Test plan
- Reset:
  - Stimulus: assert i_rstn=0 mid-RUN with VALUE=5.
  - Response: all reads return 0 and o_irq=0 immediately.
  - Stimulus: release reset.
  - Response: VALUE stays 0 with EN=0.
- One-shot:
  - Stimulus: LOAD=3, CTRL=0x5 (EN, IE, PRESC=0).
  - Response: VALUE reads 3,2,1,0 on successive cycles.
  - Response: o_irq rises 4 cycles after the EN write edge, and EN reads 0.
  - Stimulus: W1C STATUS=1.
  - Response: o_irq=0 next cycle.
- Periodic with prescaler:
  - Stimulus: LOAD=2, CTRL=0x0000_0307 (PRESC=3, AR, IE, EN).
  - Response: EXP sets every 12 cycles.
  - Response: VALUE reloads to 2 after each expiry and holds each value for 4 cycles.
- Clear/expire collision:
  - Stimulus: W1C STATUS in the exact cycle of a second periodic expiry.
  - Response: EXP remains 1.
  - Stimulus: a W1C one cycle later.
  - Response: EXP clears.
- Reload mid-run and pause:
  - Stimulus: with VALUE=7, write LOAD=20.
  - Response: VALUE reads 20 next cycle and the prescaler restarts.
  - Stimulus: write EN=0 at VALUE=15.
  - Response: VALUE holds 15 for 10 cycles.
  - Stimulus: re-enable.
  - Response: counting resumes at 14 after PRESC+1 cycles.
- Edge values:
  - Stimulus: LOAD=0, AR=1, PRESC=0.
  - Response: EXP sets every cycle and o_irq stays high.
  - Stimulus: a write to VALUE.
  - Response: ignored.
  - Stimulus: read of address 0x10.
  - Response: i_addr is 4 bits wide, so 0x10 aliases to 0x0 and returns CTRL, not 0.
  - Stimulus: LOAD=0xFFFF_FFFF with WIDTH=32.
  - Response: VALUE counts down from 0xFFFF_FFFF without wrapping.
